// File: rtl/convertidor_bin_bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM encoding, BCD limits and a digit saturation helper.
package convertidor_bin_bcd_pkg;

  typedef enum logic [1:0] {
    INACTIVO = 2'd0,
    CARGA    = 2'd1,
    DESPLAZA = 2'd2,
    LISTO    = 2'd3
  } estado_t;

  localparam int          ANCHO_DIGITO = 4;
  localparam int          NUM_NIBBLES  = 5;
  localparam logic [31:0] BCD_MAX      = 32'd9999;

  function automatic logic [ANCHO_DIGITO-1:0] digito_salida(
    input logic                    saturado,
    input logic [ANCHO_DIGITO-1:0] nibble
  );
    logic [ANCHO_DIGITO-1:0] resultado;
    if (saturado) begin
      resultado = 4'd9;
    end else begin
      resultado = nibble;
    end
    return resultado;
  endfunction

endpackage

// File: rtl/convertidor_bin_bcd_ajuste.sv
// Add-3 correction for one BCD nibble, applied before each shift.
module ajuste_bcd_digito
  import convertidor_bin_bcd_pkg::*;
(
  input  logic [ANCHO_DIGITO-1:0] entrada,
  output logic [ANCHO_DIGITO-1:0] salida
);

  // Nibbles of 5 or more would exceed 9 after doubling, so pre-correct them.
  always_comb begin
    if (entrada >= 4'd5) begin
      salida = entrada + 4'd3;
    end else begin
      salida = entrada;
    end
  end

endmodule

// File: rtl/convertidor_bin_bcd.sv
// Sequential shift-and-add-3 converter feeding the 7-segment encoder; conversions
// are started by inicio or by the refresh tick and the digits are held between them.
module convertidor_bin_bcd
  import convertidor_bin_bcd_pkg::*;
#(
  parameter int ANCHO            = 10,
  parameter int PERIODO_REFRESCO = 5_000_000
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       frecuencia,
  input  logic [ANCHO-1:0] corriente,
  input  logic             control,
  input  logic             inicio,
  output logic [3:0]       unidades,
  output logic [3:0]       decenas,
  output logic [3:0]       centenas,
  output logic [3:0]       millares,
  output logic             ocupado,
  output logic             listo,
  output logic             desborde
);

  localparam int ANCHO_BCD    = NUM_NIBBLES * ANCHO_DIGITO;
  localparam int ANCHO_ITER   = $clog2(ANCHO);
  localparam int ANCHO_CUENTA = $clog2(PERIODO_REFRESCO);
  localparam logic [ANCHO_ITER-1:0]   ITER_FIN   = ANCHO_ITER'(ANCHO - 1);
  localparam logic [ANCHO_CUENTA-1:0] CUENTA_FIN = ANCHO_CUENTA'(PERIODO_REFRESCO - 1);

  estado_t                 estado_r;
  logic [ANCHO_CUENTA-1:0] cuenta_r;
  logic [ANCHO_ITER-1:0]   iter_r;
  logic                    pendiente_r;
  logic [ANCHO_BCD-1:0]    bcd_r;
  logic [ANCHO-1:0]        bin_r;
  logic [ANCHO_BCD-1:0]    ajustado_s;
  logic [ANCHO_BCD-1:0]    bcd_final_s;
  logic [ANCHO-1:0]        operando_s;
  logic                    tick_s;
  logic                    solicitud_s;
  logic                    saturado_s;

  assign tick_s      = (cuenta_r == CUENTA_FIN);
  assign solicitud_s = inicio | tick_s;

  for (genvar i = 0; i < NUM_NIBBLES; i++) begin : g_ajuste
    ajuste_bcd_digito u_ajuste (
      .entrada (bcd_r[i*ANCHO_DIGITO +: ANCHO_DIGITO]),
      .salida  (ajustado_s[i*ANCHO_DIGITO +: ANCHO_DIGITO])
    );
  end

  // One double-dabble step: corrected accumulator shifted left, binary MSB enters bit 0.
  always_comb begin
    bcd_final_s = {ajustado_s[ANCHO_BCD-2:0], bin_r[ANCHO-1]};
    saturado_s  = ajustado_s[ANCHO_BCD-1] | (bcd_final_s[ANCHO_BCD-1:16] != 4'd0);
  end

  // Operand selection; frecuencia is zero-extended to the operand width.
  always_comb begin
    if (control) begin
      operando_s = ANCHO'(frecuencia);
    end else begin
      operando_s = corriente;
    end
  end

  // Free-running refresh counter producing the periodic conversion tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cuenta_r <= '0;
    end else if (tick_s) begin
      cuenta_r <= '0;
    end else begin
      cuenta_r <= cuenta_r + ANCHO_CUENTA'(1);
    end
  end

  // Conversion FSM with the 1-deep pending request and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_r    <= INACTIVO;
      pendiente_r <= 1'b0;
      iter_r      <= '0;
      bcd_r       <= '0;
      bin_r       <= '0;
      unidades    <= 4'd0;
      decenas     <= 4'd0;
      centenas    <= 4'd0;
      millares    <= 4'd0;
      ocupado     <= 1'b0;
      listo       <= 1'b0;
      desborde    <= 1'b0;
    end else begin
      listo <= 1'b0;
      // Requests during a conversion merge into one pending flag.
      if (solicitud_s) begin
        pendiente_r <= 1'b1;
      end
      case (estado_r)
        INACTIVO: begin
          if (pendiente_r || solicitud_s) begin
            estado_r    <= CARGA;
            ocupado     <= 1'b1;
            pendiente_r <= 1'b0;
          end
        end
        CARGA: begin
          bin_r    <= operando_s;
          bcd_r    <= '0;
          iter_r   <= '0;
          estado_r <= DESPLAZA;
        end
        DESPLAZA: begin
          {bcd_r, bin_r} <= {bcd_final_s, bin_r[ANCHO-2:0], 1'b0};
          iter_r         <= iter_r + ANCHO_ITER'(1);
          if (iter_r == ITER_FIN) begin
            estado_r <= LISTO;
            ocupado  <= 1'b0;
            listo    <= 1'b1;
            desborde <= saturado_s;
            unidades <= digito_salida(saturado_s, bcd_final_s[3:0]);
            decenas  <= digito_salida(saturado_s, bcd_final_s[7:4]);
            centenas <= digito_salida(saturado_s, bcd_final_s[11:8]);
            millares <= digito_salida(saturado_s, bcd_final_s[15:12]);
          end
        end
        LISTO: begin
          estado_r <= INACTIVO;
        end
        default: begin
          estado_r <= INACTIVO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_convertidor_bin_bcd.sv
// Directed self-checking bench: three converter instances (ANCHO=10, ANCHO=14,
// short refresh period) driven with hand-computed vectors.
module tb_convertidor_bin_bcd;

  logic        clock = 1'b0;
  logic        reset, reset_c;
  logic [7:0]  frecuencia;
  logic [9:0]  corriente;
  logic [13:0] corriente14;
  logic        control;
  logic        inicio_a, inicio_b, inicio_c;

  logic [3:0] u_a, d_a, c_a, m_a, u_b, d_b, c_b, m_b, u_c, d_c, c_c, m_c;
  logic       ocupado_a, listo_a, desborde_a;
  logic       ocupado_b, listo_b, desborde_b;
  logic       ocupado_c, listo_c, desborde_c;

  int comparaciones = 0;
  int fallos        = 0;

  always #5 clock = ~clock;

  convertidor_bin_bcd dut_a (
    .clock(clock), .reset(reset), .frecuencia(frecuencia), .corriente(corriente),
    .control(control), .inicio(inicio_a), .unidades(u_a), .decenas(d_a),
    .centenas(c_a), .millares(m_a), .ocupado(ocupado_a), .listo(listo_a),
    .desborde(desborde_a)
  );

  convertidor_bin_bcd #(.ANCHO(14)) dut_b (
    .clock(clock), .reset(reset), .frecuencia(frecuencia), .corriente(corriente14),
    .control(control), .inicio(inicio_b), .unidades(u_b), .decenas(d_b),
    .centenas(c_b), .millares(m_b), .ocupado(ocupado_b), .listo(listo_b),
    .desborde(desborde_b)
  );

  convertidor_bin_bcd #(.ANCHO(10), .PERIODO_REFRESCO(20)) dut_c (
    .clock(clock), .reset(reset_c), .frecuencia(frecuencia), .corriente(corriente),
    .control(control), .inicio(inicio_c), .unidades(u_c), .decenas(d_c),
    .centenas(c_c), .millares(m_c), .ocupado(ocupado_c), .listo(listo_c),
    .desborde(desborde_c)
  );

  task automatic comprobar(input string tag, input logic [31:0] obtenido, input logic [31:0] esperado);
    comparaciones++;
    if (obtenido !== esperado) begin
      fallos++;
      $display("FAIL %s: obtenido=%0h esperado=%0h", tag, obtenido, esperado);
    end
  endtask

  task automatic convertir_a(input string tag, input logic ctrl, input logic [7:0] f,
                             input logic [9:0] cor, input logic [15:0] esperado);
    int   k;
    logic ocu;
    @(negedge clock);
    control = ctrl; frecuencia = f; corriente = cor; inicio_a = 1'b1;
    k = 0; ocu = 1'b0;
    do begin
      @(negedge clock);
      k++;
      inicio_a = 1'b0;
      if (k == 1) ocu = ocupado_a;
    end while (!listo_a && k < 40);
    comprobar({tag, "_latencia"}, 32'(k), 32'd12);
    comprobar({tag, "_ocupado_carga"}, 32'(ocu), 32'd1);
    comprobar({tag, "_ocupado_listo"}, 32'(ocupado_a), 32'd0);
    comprobar({tag, "_digitos"}, 32'({m_a, c_a, d_a, u_a}), 32'(esperado));
    comprobar({tag, "_desborde"}, 32'(desborde_a), 32'd0);
    @(negedge clock);
    comprobar({tag, "_listo_pulso"}, 32'(listo_a), 32'd0);
  endtask

  task automatic convertir_b(input string tag, input logic [13:0] cor,
                             input logic [15:0] esperado, input logic desb);
    int k;
    @(negedge clock);
    control = 1'b0; corriente14 = cor; inicio_b = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      inicio_b = 1'b0;
    end while (!listo_b && k < 40);
    comprobar({tag, "_latencia"}, 32'(k), 32'd16);
    comprobar({tag, "_digitos"}, 32'({m_b, c_b, d_b, u_b}), 32'(esperado));
    comprobar({tag, "_desborde"}, 32'(desborde_b), 32'(desb));
  endtask

  initial begin
    int          p1, p2, k, primero;
    logic        estable;
    logic [15:0] v1, v2;

    reset = 1'b1; reset_c = 1'b1;
    frecuencia = 8'd0; corriente = 10'd0; corriente14 = 14'd0; control = 1'b0;
    inicio_a = 1'b0; inicio_b = 1'b0; inicio_c = 1'b0;
    repeat (3) @(negedge clock);
    comprobar("reset_digitos", 32'({m_a, c_a, d_a, u_a}), 32'h0);
    comprobar("reset_flags", 32'({ocupado_a, listo_a, desborde_a}), 32'h0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    comprobar("inactivo_ocupado", 32'(ocupado_a), 32'd0);

    convertir_a("c1023", 1'b0, 8'd0,   10'd1023, 16'h1023);
    convertir_a("f255",  1'b1, 8'd255, 10'd777,  16'h0255);
    convertir_a("c0",    1'b0, 8'd0,   10'd0,    16'h0000);
    convertir_a("c9",    1'b0, 8'd0,   10'd9,    16'h0009);

    // Back-to-back: second request arrives mid-conversion and is served next.
    @(negedge clock);
    control = 1'b0; corriente = 10'd100; inicio_a = 1'b1;
    p1 = -1; p2 = -1; estable = 1'b1; v1 = 16'h0; v2 = 16'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      inicio_a = (c == 4);
      if (c == 2) corriente = 10'd200;
      if (listo_a) begin
        if (p1 < 0) begin
          p1 = c; v1 = {m_a, c_a, d_a, u_a};
        end else if (p2 < 0) begin
          p2 = c; v2 = {m_a, c_a, d_a, u_a};
        end
      end else if (p1 >= 0 && p2 < 0 && {m_a, c_a, d_a, u_a} !== 16'h0100) begin
        estable = 1'b0;
      end
    end
    comprobar("b2b_listo1_ciclo", 32'(p1), 32'd12);
    comprobar("b2b_digitos1", 32'(v1), 32'h0100);
    comprobar("b2b_listo2_ciclo", 32'(p2), 32'd25);
    comprobar("b2b_digitos2", 32'(v2), 32'h0200);
    comprobar("b2b_estable", 32'(estable), 32'd1);

    convertir_b("w12000", 14'd12000, 16'h9999, 1'b1);
    convertir_b("w4321",  14'd4321,  16'h4321, 1'b0);
    convertir_b("w9999",  14'd9999,  16'h9999, 1'b0);

    // Refresh-driven instance: first tick after 20 cycles, then every 20.
    @(negedge clock);
    control = 1'b0; corriente = 10'd345;
    reset_c = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (!listo_c && k < 60);
    comprobar("ref_primer_listo", 32'(k), 32'd31);
    comprobar("ref_digitos", 32'({m_c, c_c, d_c, u_c}), 32'h0345);
    for (int r = 0; r < 2; r++) begin
      k = 0;
      do begin @(negedge clock); k++; end while (!listo_c && k < 60);
      comprobar("ref_periodo", 32'(k), 32'd20);
    end

    // Reset in the middle of DESPLAZA clears outputs at once.
    repeat (13) @(negedge clock);
    comprobar("ref_en_desplaza", 32'(ocupado_c), 32'd1);
    reset_c = 1'b1;
    #1;
    comprobar("rst_digitos", 32'({m_c, c_c, d_c, u_c}), 32'h0);
    comprobar("rst_flags", 32'({ocupado_c, listo_c, desborde_c}), 32'h0);
    repeat (3) @(negedge clock);
    reset_c = 1'b0;
    primero = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (listo_c && primero < 0) primero = c;
    end
    comprobar("rst_siguiente_listo", 32'(primero), 32'd31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparaciones, fallos);
    $finish;
  end

endmodule
